// File: rtl/ie_interrupt_handler_pkg.sv
// Shared definitions for the IE interrupt/return sequencer.
package ie_defs;

    // Vector locations (low byte address; high byte follows)
    localparam logic [15:0] VecNmi   = 16'hFFFA;
    localparam logic [15:0] VecReset = 16'hFFFC;
    localparam logic [15:0] VecIrq   = 16'hFFFE;

    localparam logic [7:0] StackPage = 8'h01;

    // Processor status bit positions
    localparam int unsigned StatusC = 0;
    localparam int unsigned StatusZ = 1;
    localparam int unsigned StatusI = 2;
    localparam int unsigned StatusD = 3;
    localparam int unsigned StatusB = 4;
    localparam int unsigned StatusU = 5;
    localparam int unsigned StatusV = 6;
    localparam int unsigned StatusN = 7;

    typedef enum logic [2:0] {
        StIdle,
        StPushHi,
        StPushLo,
        StPushP,
        StRdAddr,
        StRdWait,
        StRdLatch,
        StFinish
    } ie_state_e;

    typedef enum logic [2:0] {
        PathPass,
        PathBrk,
        PathNmi,
        PathRti,
        PathRst
    } ie_path_e;

    function automatic logic [15:0] vector_addr(input ie_path_e path);
        case (path)
            PathNmi: return VecNmi;
            PathRst: return VecReset;
            default: return VecIrq;
        endcase
    endfunction

    // Status byte as written to the stack: U always set, B marks BRK vs NMI.
    function automatic logic [7:0] pushed_status(input logic [7:0] status, input logic brk);
        logic [7:0] s;
        s          = status;
        s[StatusU] = 1'b1;
        s[StatusB] = brk;
        return s;
    endfunction

    // Status byte restored by RTI: B does not exist in the live register.
    function automatic logic [7:0] pulled_status(input logic [7:0] status);
        logic [7:0] s;
        s          = status;
        s[StatusB] = 1'b0;
        s[StatusU] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/ie_interrupt_handler_edge_latch.sv
// Rising-edge detector feeding a sticky pending flag.
module edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    input  logic clr,
    output logic pend
);

    logic prev_q;
    logic pend_q;
    logic pend_d;

    // A fresh edge wins over a same-cycle clear so it is never lost.
    always_comb begin
        pend_d = (sig & ~prev_q) | (pend_q & ~clr);
    end

    // Edge history and pending flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= sig;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/ie_interrupt_handler.sv
// Interrupt/return sequencer: soft reset, RTI, BRK and NMI over the shared memory bus.
module ie_interrupt_handler
    import ie_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        write_en,
    input  logic        is_break,
    input  logic [7:0]  ppu_status,
    input  logic        soft_reset,
    input  logic        is_rti,
    input  logic        start,
    output logic        done,
    output logic        busy,
    input  logic [15:0] pc_in,
    input  logic [7:0]  status_in,
    input  logic [7:0]  stack_in,
    output logic [15:0] pc_out,
    output logic [7:0]  status_out,
    output logic [7:0]  stack_out
);

    ie_state_e   state_q, state_d;
    ie_path_e    path_q, path_d;
    logic [15:0] pc_w_q, pc_w_d;
    logic [7:0]  status_w_q, status_w_d;
    logic [7:0]  sp_q, sp_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        write_en_q, write_en_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [7:0]  status_out_q, status_out_d;
    logic [7:0]  stack_out_q, stack_out_d;

    logic        nmi_pend, rst_pend;
    logic        nmi_clr, rst_clr;
    logic [7:0]  sp_inc, sp_dec;
    logic [1:0]  rd_last;
    logic        unused_ppu;

    // Only the vblank bit matters here.
    assign unused_ppu = ^ppu_status[6:0];

    edge_latch u_nmi_latch (
        .clk  (clk),
        .rst  (rst),
        .sig  (ppu_status[7]),
        .clr  (nmi_clr),
        .pend (nmi_pend)
    );

    edge_latch u_rst_latch (
        .clk  (clk),
        .rst  (rst),
        .sig  (soft_reset),
        .clr  (rst_clr),
        .pend (rst_pend)
    );

    assign sp_inc  = sp_q + 8'd1;
    assign sp_dec  = sp_q - 8'd1;
    assign rd_last = (path_q == PathRti) ? 2'd2 : 2'd1;

    // Next-state, bus and result computation.
    always_comb begin
        state_d      = state_q;
        path_d       = path_q;
        pc_w_d       = pc_w_q;
        status_w_d   = status_w_q;
        sp_d         = sp_q;
        rd_idx_d     = rd_idx_q;
        addr_d       = addr_q;
        data_out_d   = data_out_q;
        write_en_d   = 1'b0;
        done_d       = done_q;
        pc_out_d     = pc_out_q;
        status_out_d = status_out_q;
        stack_out_d  = stack_out_q;
        nmi_clr      = 1'b0;
        rst_clr      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pc_w_d     = pc_in;
                    status_w_d = status_in;
                    sp_d       = stack_in;
                    rd_idx_d   = 2'd0;
                    done_d     = 1'b0;
                    if (rst_pend) begin
                        path_d              = PathRst;
                        rst_clr             = 1'b1;
                        sp_d                = stack_in - 8'd3;
                        status_w_d[StatusI] = 1'b1;
                        state_d             = StRdAddr;
                    end else if (is_rti) begin
                        path_d  = PathRti;
                        state_d = StRdAddr;
                    end else if (is_break) begin
                        path_d  = PathBrk;
                        state_d = StPushHi;
                    end else if (nmi_pend) begin
                        path_d  = PathNmi;
                        nmi_clr = 1'b1;
                        state_d = StPushHi;
                    end else begin
                        path_d  = PathPass;
                        state_d = StFinish;
                    end
                end
            end
            StPushHi: begin
                addr_d     = {StackPage, sp_q};
                data_out_d = pc_w_q[15:8];
                write_en_d = 1'b1;
                sp_d       = sp_dec;
                state_d    = StPushLo;
            end
            StPushLo: begin
                addr_d     = {StackPage, sp_q};
                data_out_d = pc_w_q[7:0];
                write_en_d = 1'b1;
                sp_d       = sp_dec;
                state_d    = StPushP;
            end
            StPushP: begin
                addr_d              = {StackPage, sp_q};
                data_out_d          = pushed_status(status_w_q, path_q == PathBrk);
                write_en_d          = 1'b1;
                sp_d                = sp_dec;
                status_w_d[StatusI] = 1'b1;
                state_d             = StRdAddr;
            end
            StRdAddr: begin
                if (path_q == PathRti) begin
                    sp_d   = sp_inc;
                    addr_d = {StackPage, sp_inc};
                end else begin
                    addr_d = vector_addr(path_q) + {14'd0, rd_idx_q};
                end
                state_d = StRdWait;
            end
            StRdWait: begin
                state_d = StRdLatch;
            end
            StRdLatch: begin
                if (path_q == PathRti) begin
                    case (rd_idx_q)
                        2'd0:    status_w_d   = pulled_status(data_in);
                        2'd1:    pc_w_d[7:0]  = data_in;
                        default: pc_w_d[15:8] = data_in;
                    endcase
                end else if (rd_idx_q == 2'd0) begin
                    pc_w_d[7:0] = data_in;
                end else begin
                    pc_w_d[15:8] = data_in;
                end
                rd_idx_d = rd_idx_q + 2'd1;
                state_d  = (rd_idx_q == rd_last) ? StFinish : StRdAddr;
            end
            StFinish: begin
                pc_out_d     = pc_w_q;
                status_out_d = status_w_q;
                stack_out_d  = sp_q;
                done_d       = 1'b1;
                state_d      = StIdle;
            end
        endcase

        // Bus ownership starts with the first registered bus cycle, ends entering FINISH.
        busy_d = (state_q != StIdle) && (state_d != StIdle) && (state_d != StFinish);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            path_q       <= PathPass;
            pc_w_q       <= 16'h0000;
            status_w_q   <= 8'h00;
            sp_q         <= 8'hFF;
            rd_idx_q     <= 2'd0;
            addr_q       <= 16'h0000;
            data_out_q   <= 8'h00;
            write_en_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            pc_out_q     <= 16'h0000;
            status_out_q <= 8'h00;
            stack_out_q  <= 8'hFF;
        end else begin
            state_q      <= state_d;
            path_q       <= path_d;
            pc_w_q       <= pc_w_d;
            status_w_q   <= status_w_d;
            sp_q         <= sp_d;
            rd_idx_q     <= rd_idx_d;
            addr_q       <= addr_d;
            data_out_q   <= data_out_d;
            write_en_q   <= write_en_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            pc_out_q     <= pc_out_d;
            status_out_q <= status_out_d;
            stack_out_q  <= stack_out_d;
        end
    end

    assign addr       = addr_q;
    assign data_out   = data_out_q;
    assign write_en   = write_en_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign pc_out     = pc_out_q;
    assign status_out = status_out_q;
    assign stack_out  = stack_out_q;

endmodule

// File: tb/tb_ie_interrupt_handler.sv
// Self-checking bench for ie_interrupt_handler: transaction-level reference model plus
// directed literal checks and randomized traffic.
module tb_ie_interrupt_handler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        write_en;
    logic        is_break = 1'b0;
    logic [7:0]  ppu_status = 8'h00;
    logic        soft_reset = 1'b0;
    logic        is_rti = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic        busy;
    logic [15:0] pc_in = 16'h0000;
    logic [7:0]  status_in = 8'h00;
    logic [7:0]  stack_in = 8'h00;
    logic [15:0] pc_out;
    logic [7:0]  status_out;
    logic [7:0]  stack_out;

    logic [7:0]  mem [0:65535];
    int          errors = 0;
    int          checks = 0;
    bit          rnd_ev = 1'b0;

    ie_interrupt_handler dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .write_en   (write_en),
        .is_break   (is_break),
        .ppu_status (ppu_status),
        .soft_reset (soft_reset),
        .is_rti     (is_rti),
        .start      (start),
        .done       (done),
        .busy       (busy),
        .pc_in      (pc_in),
        .status_in  (status_in),
        .stack_in   (stack_in),
        .pc_out     (pc_out),
        .status_out (status_out),
        .stack_out  (stack_out)
    );

    assign data_in = mem[addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_active = 0, m_done = 0, m_nmi = 0, m_rstp = 0, m_prev_v = 0, m_prev_s = 0;
    bit          rise_v, rise_s;
    int          m_cnt = 0, m_lat = 0, m_nw = 0, m_nr = 0;
    logic [15:0] m_waddr [3];
    logic [7:0]  m_wdata [3];
    logic [15:0] m_raddr [3];
    logic [15:0] m_pc_out = 16'h0000, m_pc_next = 16'h0000;
    logic [7:0]  m_st_out = 8'h00, m_st_next = 8'h00;
    logic [7:0]  m_sp_out = 8'hFF, m_sp_next = 8'h00;

    task automatic model_push_vector(input bit nmi);
        logic [15:0] v;
        logic [7:0]  sp;
        v  = nmi ? 16'hFFFA : 16'hFFFE;
        sp = stack_in;
        m_nw = 3; m_nr = 2; m_lat = 10;
        m_waddr[0] = {8'h01, sp}; m_wdata[0] = pc_in[15:8]; sp = sp - 8'd1;
        m_waddr[1] = {8'h01, sp}; m_wdata[1] = pc_in[7:0];  sp = sp - 8'd1;
        m_waddr[2] = {8'h01, sp};
        m_wdata[2] = nmi ? ((status_in | 8'h20) & 8'hEF) : (status_in | 8'h30);
        sp = sp - 8'd1;
        m_raddr[0] = v;
        m_raddr[1] = v + 16'd1;
        m_pc_next  = {mem[m_raddr[1]], mem[m_raddr[0]]};
        m_st_next  = status_in | 8'h04;
        m_sp_next  = sp;
    endtask

    task automatic model_rti();
        logic [7:0] sp;
        sp = stack_in;
        m_nw = 0; m_nr = 3; m_lat = 10;
        for (int k = 0; k < 3; k++) begin
            sp = sp + 8'd1;
            m_raddr[k] = {8'h01, sp};
        end
        m_st_next = (mem[m_raddr[0]] & 8'hEF) | 8'h20;
        m_pc_next = {mem[m_raddr[2]], mem[m_raddr[1]]};
        m_sp_next = sp;
    endtask

    task automatic model_soft_reset();
        m_nw = 0; m_nr = 2; m_lat = 7;
        m_raddr[0] = 16'hFFFC;
        m_raddr[1] = 16'hFFFD;
        m_pc_next  = {mem[16'hFFFD], mem[16'hFFFC]};
        m_st_next  = status_in | 8'h04;
        m_sp_next  = stack_in - 8'd3;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_active = 0; m_done = 0; m_nmi = 0; m_rstp = 0; m_prev_v = 0; m_prev_s = 0;
            m_cnt = 0; m_pc_out = 16'h0000; m_st_out = 8'h00; m_sp_out = 8'hFF;
        end else begin
            rise_v = ppu_status[7] && !m_prev_v;
            rise_s = soft_reset && !m_prev_s;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == m_lat) begin
                    m_active = 0;
                    m_done   = 1;
                    m_pc_out = m_pc_next;
                    m_st_out = m_st_next;
                    m_sp_out = m_sp_next;
                end
            end else if (start) begin
                m_active = 1; m_done = 0; m_cnt = 0; m_nw = 0; m_nr = 0;
                if (m_rstp) begin
                    m_rstp = 0;
                    model_soft_reset();
                end else if (is_rti) begin
                    model_rti();
                end else if (is_break) begin
                    model_push_vector(1'b0);
                end else if (m_nmi) begin
                    m_nmi = 0;
                    model_push_vector(1'b1);
                end else begin
                    m_lat = 1;
                    m_pc_next = pc_in; m_st_next = status_in; m_sp_next = stack_in;
                end
            end
            if (rise_v) m_nmi = 1;
            if (rise_s) m_rstp = 1;
            m_prev_v = ppu_status[7];
            m_prev_s = soft_reset;
        end
    end

    // ---------------- per-cycle compare (also applies bus writes to memory) ----------------
    bit exp_we, exp_busy;
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_addr", addr, 16'h0000);
            chk("rst_data_out", data_out, 8'h00);
            chk("rst_write_en", write_en, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_pc_out", pc_out, 16'h0000);
            chk("rst_status_out", status_out, 8'h00);
            chk("rst_stack_out", stack_out, 8'hFF);
        end else begin
            exp_we = m_active && m_cnt >= 1 && m_cnt <= m_nw;
            chk("write_en", write_en, exp_we);
            if (exp_we) begin
                chk("wr_addr", addr, m_waddr[m_cnt-1]);
                chk("wr_data", data_out, m_wdata[m_cnt-1]);
            end
            if (write_en) mem[addr] = data_out;
            exp_busy = m_active && m_cnt >= 1 && m_cnt <= m_lat - 2;
            chk("busy", busy, exp_busy);
            if (m_active && m_nr > 0 && m_cnt > m_nw && m_cnt <= m_lat - 2)
                chk("rd_addr", addr, m_raddr[(m_cnt - m_nw - 1) / 3]);
            chk("done", done, m_done);
            chk("pc_out", pc_out, m_pc_out);
            chk("status_out", status_out, m_st_out);
            chk("stack_out", stack_out, m_sp_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic random_events();
        ppu_status[6:0] = 7'($urandom);
        if ($urandom_range(0, 5) == 0) ppu_status[7] = ~ppu_status[7];
        if ($urandom_range(0, 15) == 0) soft_reset = ~soft_reset;
    endtask

    task automatic run(input logic [15:0] p, input logic [7:0] s, input logic [7:0] sp,
                       input bit b, input bit r, output int lat, output bit bs);
        step();
        pc_in = p; status_in = s; stack_in = sp; is_break = b; is_rti = r; start = 1'b1;
        step();
        start = 1'b0; is_break = 1'b0; is_rti = 1'b0;
        bs  = busy;
        lat = 0;
        while (lat < 20 && !done) begin
            if (rnd_ev) begin
                random_events();
                if ($urandom_range(0, 5) == 0) start = 1'b1;
            end
            step();
            start = 1'b0;
            lat++;
            if (busy) bs = 1'b1;
        end
        if (!done) chk("done_timeout", done, 1'b1);
    endtask

    initial begin
        int lat;
        bit bs;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        #1 rst = 1'b0;
        step();
        step();
        chk("lit_reset_stack_out", stack_out, 8'hFF);
        chk("lit_reset_done", done, 1'b0);
        rst = 1'b1;

        // Pass-through
        run(16'hC123, 8'h24, 8'hFD, 1'b0, 1'b0, lat, bs);
        chk("lit_pass_lat", lat, 1);
        chk("lit_pass_busy", bs, 1'b0);
        chk("lit_pass_pc", pc_out, 16'hC123);
        chk("lit_pass_sp", stack_out, 8'hFD);
        chk("lit_pass_status", status_out, 8'h24);

        // BRK
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h90;
        run(16'h8002, 8'h20, 8'hFF, 1'b1, 1'b0, lat, bs);
        chk("lit_brk_lat", lat, 10);
        chk("lit_brk_push_hi", mem[16'h01FF], 8'h80);
        chk("lit_brk_push_lo", mem[16'h01FE], 8'h02);
        chk("lit_brk_push_p", mem[16'h01FD], 8'h30);
        chk("lit_brk_pc", pc_out, 16'h9000);
        chk("lit_brk_status", status_out, 8'h24);
        chk("lit_brk_sp", stack_out, 8'hFC);

        // NMI, then a pass-through
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'hA0;
        ppu_status = 8'h80;
        step();
        run(16'h8010, 8'h20, 8'hFF, 1'b0, 1'b0, lat, bs);
        chk("lit_nmi_pc", pc_out, 16'hA000);
        chk("lit_nmi_push_p", mem[16'h01FD], 8'h20);
        chk("lit_nmi_push_lo", mem[16'h01FE], 8'h10);
        chk("lit_nmi_sp", stack_out, 8'hFC);
        run(16'h4455, 8'h01, 8'hF0, 1'b0, 1'b0, lat, bs);
        chk("lit_nmi_second_lat", lat, 1);
        chk("lit_nmi_second_pc", pc_out, 16'h4455);
        ppu_status = 8'h00;

        // RTI
        mem[16'h01FD] = 8'hC3; mem[16'h01FE] = 8'h34; mem[16'h01FF] = 8'h12;
        run(16'h0000, 8'h00, 8'hFC, 1'b0, 1'b1, lat, bs);
        chk("lit_rti_lat", lat, 10);
        chk("lit_rti_pc", pc_out, 16'h1234);
        chk("lit_rti_status", status_out, 8'hE3);
        chk("lit_rti_sp", stack_out, 8'hFF);

        // Priority: BRK beats a pending NMI, NMI follows
        ppu_status = 8'h80;
        step();
        run(16'h2000, 8'h00, 8'hFF, 1'b1, 1'b0, lat, bs);
        chk("lit_prio_brk_pc", pc_out, 16'h9000);
        chk("lit_prio_brk_p", mem[16'h01FD], 8'h30);
        run(16'h3000, 8'h00, 8'hFF, 1'b0, 1'b0, lat, bs);
        chk("lit_prio_nmi_pc", pc_out, 16'hA000);
        chk("lit_prio_nmi_p", mem[16'h01FD], 8'h20);
        ppu_status = 8'h00;

        // Reset during PUSH_LO, then soft reset
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        step();
        pc_in = 16'h5678; status_in = 8'h00; stack_in = 8'hFF; is_break = 1'b1; start = 1'b1;
        step();
        start = 1'b0; is_break = 1'b0;
        step();
        chk("lit_mid_we_before", write_en, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("lit_mid_we", write_en, 1'b0);
        chk("lit_mid_busy", busy, 1'b0);
        chk("lit_mid_done", done, 1'b0);
        chk("lit_mid_stack_out", stack_out, 8'hFF);
        step();
        rst = 1'b1;
        soft_reset = 1'b1;
        step();
        run(16'h1234, 8'h00, 8'hFF, 1'b0, 1'b0, lat, bs);
        chk("lit_srst_lat", lat, 7);
        chk("lit_srst_pc", pc_out, 16'h8000);
        chk("lit_srst_sp", stack_out, 8'hFC);
        chk("lit_srst_i", status_out[2], 1'b1);
        soft_reset = 1'b0;

        // Randomized traffic
        rnd_ev = 1'b1;
        for (int i = 0; i < 256; i++) mem[16'h0100 + i] = 8'($urandom);
        for (int it = 0; it < 150; it++) begin
            int sel;
            for (int j = 0; j < 6; j++) mem[16'hFFFA + j] = 8'($urandom);
            sel = $urandom_range(0, 3);
            run(16'($urandom), 8'($urandom), 8'($urandom), sel == 1, sel == 2, lat, bs);
            repeat ($urandom_range(0, 3)) begin
                random_events();
                step();
            end
        end
        rnd_ev = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/ie_interrupt_handler.md
# ie_interrupt_handler

Interrupt/return sequencer for the 6502-style instruction-execute (IE) unit. It runs once per instruction, after the IE FSM completes the instruction and pulses `interrupt_start`. It services soft reset, RTI, BRK and PPU vblank NMI by driving the shared memory bus for stack pushes/pulls and vector fetches, then returns the next PC, status and stack pointer. With nothing to service, it passes its inputs straight through.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `addr` out 16: memory address, valid while `busy`.
- `data_in` in 8: memory read data.
- `data_out` out 8: memory write data.
- `write_en` out 1: memory write strobe, one cycle per byte.
- `is_break` in 1: current instruction is BRK.
- `ppu_status` in 8: bit 7 is vblank; a rising edge requests NMI.
- `soft_reset` in 1: a rising edge requests a soft reset.
- `is_rti` in 1: current instruction is RTI.
- `start` in 1: one-cycle request to run the sequence.
- `done` out 1: sequence complete; outputs valid.
- `busy` out 1: handler owns the memory bus.
- `pc_in` in 16, `status_in` in 8, `stack_in` in 8: CPU state, sampled on `start`.
- `pc_out` out 16, `status_out` out 8, `stack_out` out 8: resulting CPU state.

## Operation
- Pending latches:
  - `nmi_pend` sets on a 0→1 edge of `ppu_status[7]`.
  - `rst_pend` sets on a 0→1 edge of `soft_reset`.
  - Both are edge-detected every cycle, independent of state, and cleared only when serviced.
- On `start` in IDLE:
  - Capture `pc_in`, `status_in`, `stack_in` into working registers; clear `done`.
  - Select one path by priority: `rst_pend` > `is_rti` > `is_break` > `nmi_pend`, else pass-through.
  - An unserviced NMI stays pending for the next `start`.
- Stack addresses are {8'h01, sp}, with 8-bit wrap-around. A push writes at sp and then decrements sp; a pull increments sp and then reads.
- Pass-through: outputs equal the captured inputs; `busy` stays 0.
- BRK:
  - Push PC[15:8], then PC[7:0], then status with bit 4 = 1 and bit 5 = 1.
  - Set I (bit 2).
  - Fetch the vector at $FFFE (low) and $FFFF (high).
- NMI: identical to BRK except the pushed bit 4 = 0 and the vector is at $FFFA/$FFFB. Clears `nmi_pend`.
- RTI:
  - Pull status, then PC low, then PC high.
  - `status_out` is the pulled byte with bit 4 forced 0 and bit 5 forced 1.
- Soft reset:
  - No writes; sp = sp − 3.
  - Set I.
  - Fetch the vector at $FFFC/$FFFD.
  - Clears `rst_pend`.
- `is_break`/`is_rti` are ignored outside IDLE.
- `start` while not IDLE is ignored.

## Timing
- States: IDLE, PUSH_HI, PUSH_LO, PUSH_P, RD_ADDR, RD_WAIT, RD_LATCH, FINISH.
- Write timing: each push cycle registers `addr`/`data_out` with `write_en` = 1 for exactly one cycle.
- Read timing:
  - `addr` is registered on edge N.
  - `data_in` is sampled on edge N+2.
  - Each byte read therefore takes 3 states.
- Latency from the `start` edge to `done` high:
  - Pass-through: 1 cycle.
  - BRK/NMI: 3 writes + 2 reads = 10 cycles.
  - RTI: 3 reads = 10 cycles.
  - Soft reset: 2 reads = 7 cycles.
- `busy` is high from the first bus cycle through the last read, and low in IDLE/FINISH.
- `done` is registered. It rises together with `pc_out`/`status_out`/`stack_out` and holds until the next accepted `start`.
- Reset values: `addr` = 0, `data_out` = 0, `write_en` = 0, `done` = 0, `busy` = 0, `pc_out` = 0, `status_out` = 8'h00, `stack_out` = 8'hFF, pending latches 0, edge history 0, state IDLE.
- Asserting reset mid-sequence aborts the sequence immediately; no partial outputs survive.

## Structure
- Shared package `ie_defs` holds:
  - Vector addresses: NMI $FFFA, RESET $FFFC, IRQ/BRK $FFFE.
  - Stack page 8'h01.
  - Status bit indices: C = 0, Z = 1, I = 2, D = 3, B = 4, U = 5, V = 6, N = 7.
  - The state enum.
- One sub-module: `edge_latch` (rising-edge detect plus set/clear pending flag), instantiated twice.

## Test plan
- Pass-through:
  - Stimulus: pc_in = $C123, status = $24, sp = $FD, `start`, no flags.
  - Response: 1 cycle later `done`, pc_out = $C123, sp = $FD, `busy` never high.
- BRK:
  - Stimulus: pc_in = $8002, status = $20, sp = $FF; memory $FFFE = $00, $FFFF = $90.
  - Response: writes $01FF←$80, $01FE←$02, $01FD←$30; pc_out = $9000, status_out = $24, sp = $FC.
- NMI:
  - Stimulus: rise `ppu_status[7]`, then `start` with pc = $8010, sp = $FF; vector $FFFA/$FFFB = $00/$A0.
  - Response: pushed status has bit 4 = 0; pc_out = $A000; a second `start` passes through.
- RTI:
  - Stimulus: sp = $FC; stack $01FD = $C3, $01FE = $34, $01FF = $12.
  - Response: pc_out = $1234, status_out = $E3, sp = $FF.
- Priority:
  - Stimulus: NMI pending together with BRK.
  - Response: BRK serviced first; the next `start` services NMI.
- Reset:
  - Stimulus: assert `rst` during PUSH_LO.
  - Response: `write_en`/`busy`/`done` = 0 and `stack_out` = $FF immediately.
  - Follow-up: rising `soft_reset` then `start` with sp = $FF and $FFFC/$FFFD = $00/$80 gives pc_out = $8000, sp = $FC, I set.
